color_regfile: RTL and testbench

//   Colour register file for the VGA colour processor. Holds four 24-bit RGB colours, one per

---
 rtl/color_regfile_if.sv | 24 ++
 rtl/color_regfile.sv | 110 +++++++++++
 tb/tb_color_regfile.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/color_regfile_if.sv
// Bus bundle for the colour register file. It carries the write/step handshake from the
// controller and the four colour outputs back to the renderer.
interface color_regfile_if;
    logic        color_next;
    logic [1:0]  channel;
    logic [3:0]  data;
    logic [3:0]  address;
    logic        valid;
    logic        ack;
    logic [23:0] rgb0;
    logic [23:0] rgb1;
    logic [23:0] rgb2;
    logic [23:0] rgb3;

    modport master (
        output color_next, channel, data, address, valid,
        input  ack, rgb0, rgb1, rgb2, rgb3
    );

    modport slave (
        input  color_next, channel, data, address, valid,
        output ack, rgb0, rgb1, rgb2, rgb3
    );
endinterface

// File: rtl/color_regfile.sv
// Four-channel 24-bit colour register file with nibble writes and an 8-entry preset palette.
// Define SYNC_INPUTS_EN to add 2-flop synchronizers on valid and color_next.
module color_regfile (
    input  logic            clk,
    input  logic            rst,
    color_regfile_if.slave  bus
);
    logic [2:0]  idx_q [4];
    logic [2:0]  idx_d [4];
    logic [23:0] rgb_q [4];
    logic [23:0] rgb_d [4];
    logic        ack_q, ack_d;
    logic        valid_prev_q, valid_prev_d;
    logic        next_prev_q, next_prev_d;
    logic        valid_in, next_in;
    logic        valid_rise, next_rise;

    function automatic logic [23:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    palette = 24'h000000;
            3'd1:    palette = 24'hFFFFFF;
            3'd2:    palette = 24'hFF0000;
            3'd3:    palette = 24'h00FF00;
            3'd4:    palette = 24'h0000FF;
            3'd5:    palette = 24'hFFFF00;
            3'd6:    palette = 24'h00FFFF;
            default: palette = 24'hFF00FF;
        endcase
    endfunction

`ifdef SYNC_INPUTS_EN
    // Synchronizer stages reset high so a level held through reset never looks like an edge.
    logic valid_s1_q, valid_s2_q, next_s1_q, next_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_s1_q <= 1'b1;
            valid_s2_q <= 1'b1;
            next_s1_q  <= 1'b1;
            next_s2_q  <= 1'b1;
        end else begin
            valid_s1_q <= bus.valid;
            valid_s2_q <= valid_s1_q;
            next_s1_q  <= bus.color_next;
            next_s2_q  <= next_s1_q;
        end
    end

    assign valid_in = valid_s2_q;
    assign next_in  = next_s2_q;
`else
    assign valid_in = bus.valid;
    assign next_in  = bus.color_next;
`endif

    assign valid_rise = valid_in & ~valid_prev_q;
    assign next_rise  = next_in & ~next_prev_q;

    always_comb begin
        valid_prev_d = valid_in;
        next_prev_d  = next_in;
        ack_d        = valid_rise;
        for (int c = 0; c < 4; c++) begin
            idx_d[c] = idx_q[c];
            rgb_d[c] = rgb_q[c];
            if (next_rise && bus.channel == 2'(c)) begin
                idx_d[c] = idx_q[c] + 3'd1;
                rgb_d[c] = palette(idx_q[c] + 3'd1);
            end
            // The nibble write lands after the palette load so it wins on a shared edge.
            if (valid_rise && bus.channel == 2'(c)) begin
                case (bus.address)
                    4'd3:    rgb_d[c][23:20] = bus.data;
                    4'd4:    rgb_d[c][19:16] = bus.data;
                    4'd5:    rgb_d[c][15:12] = bus.data;
                    4'd6:    rgb_d[c][11:8]  = bus.data;
                    4'd7:    rgb_d[c][7:4]   = bus.data;
                    4'd8:    rgb_d[c][3:0]   = bus.data;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q        <= 1'b0;
            valid_prev_q <= 1'b1;
            next_prev_q  <= 1'b1;
            for (int c = 0; c < 4; c++) begin
                idx_q[c] <= 3'(c + 1);
                rgb_q[c] <= palette(3'(c + 1));
            end
        end else begin
            ack_q        <= ack_d;
            valid_prev_q <= valid_prev_d;
            next_prev_q  <= next_prev_d;
            for (int c = 0; c < 4; c++) begin
                idx_q[c] <= idx_d[c];
                rgb_q[c] <= rgb_d[c];
            end
        end
    end

    assign bus.ack  = ack_q;
    assign bus.rgb0 = rgb_q[0];
    assign bus.rgb1 = rgb_q[1];
    assign bus.rgb2 = rgb_q[2];
    assign bus.rgb3 = rgb_q[3];
endmodule

// File: tb/tb_color_regfile.sv
// Directed testbench for color_regfile: nibble writes, palette stepping, reset and
// simultaneous write/step behaviour with hand-computed expected colours.
module tb_color_regfile;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    color_regfile_if bus ();

    color_regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %06h expected %06h", tag, got, exp);
        end else begin
            $display("ok   %s: %06h", tag, got);
        end
    endtask

    task automatic check_all(input string tag, input logic [23:0] e0, input logic [23:0] e1,
                             input logic [23:0] e2, input logic [23:0] e3);
        check_eq({tag, " rgb0"}, bus.rgb0, e0);
        check_eq({tag, " rgb1"}, bus.rgb1, e1);
        check_eq({tag, " rgb2"}, bus.rgb2, e2);
        check_eq({tag, " rgb3"}, bus.rgb3, e3);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        bus.valid      = 1'b0;
        bus.color_next = 1'b0;
        rst            = 1'b1;
        #12;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One write: ack must be high exactly one cycle, with the new value already visible.
    task automatic do_write(input logic [1:0] ch, input logic [3:0] addr, input logic [3:0] d);
        @(posedge clk);
        #1;
        bus.channel = ch;
        bus.address = addr;
        bus.data    = d;
        bus.valid   = 1'b1;
        @(posedge clk);
        #1;
        check_eq($sformatf("ack hi ch%0d a%0d", ch, addr), {23'd0, bus.ack}, 24'd1);
        bus.valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq($sformatf("ack lo ch%0d a%0d", ch, addr), {23'd0, bus.ack}, 24'd0);
    endtask

    task automatic pulse_next(input logic [1:0] ch);
        @(posedge clk);
        #1;
        bus.channel    = ch;
        bus.color_next = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.color_next = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] sel_rgb(input logic [1:0] ch);
        case (ch)
            2'd0:    sel_rgb = bus.rgb0;
            2'd1:    sel_rgb = bus.rgb1;
            2'd2:    sel_rgb = bus.rgb2;
            default: sel_rgb = bus.rgb3;
        endcase
    endfunction

    logic [23:0] steps0 [5];
    logic [3:0]  fill   [4];
    logic [23:0] filled [4];

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.valid      = 1'b0;
        bus.color_next = 1'b0;
        bus.channel    = 2'd0;
        bus.address    = 4'd0;
        bus.data       = 4'd0;
        steps0 = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00, 24'h00FFFF};
        fill   = '{4'hA, 4'h5, 4'h9, 4'h6};
        filled = '{24'hAAAAAA, 24'h555555, 24'h999999, 24'h666666};

        #22;
        check_all("reset", 24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF);
        check_eq("reset ack", {23'd0, bus.ack}, 24'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Channel 0 fill, other channels untouched
        for (int a = 3; a <= 8; a++) do_write(2'd0, 4'(a), fill[0]);
        check_all("fill ch0", 24'hAAAAAA, 24'hFF0000, 24'h00FF00, 24'h0000FF);

        for (int c = 1; c < 4; c++) begin
            for (int a = 3; a <= 8; a++) do_write(2'(c), 4'(a), fill[c]);
            check_eq($sformatf("fill ch%0d", c), sel_rgb(2'(c)), filled[c]);
        end
        check_eq("fill keep ch0", bus.rgb0, 24'hAAAAAA);

        // Async reset with valid held high through release
        @(posedge clk);
        #3;
        bus.valid = 1'b1;
        rst       = 1'b1;
        #1;
        check_all("async rst", 24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF);
        #10;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("held valid no ack %0d", i), {23'd0, bus.ack}, 24'd0);
        end
        check_eq("held valid no write", bus.rgb0, 24'hFFFFFF);
        bus.valid = 1'b0;

        // Palette stepping with wrap
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pulse_next(2'd0);
            check_eq($sformatf("step ch0 #%0d", i), bus.rgb0, steps0[i]);
        end
        for (int i = 0; i < 5; i++) pulse_next(2'd2);
        check_eq("step ch2 wrap", bus.rgb2, 24'h000000);
        check_eq("step keep ch0", bus.rgb0, 24'h00FFFF);
        check_eq("step keep ch1", bus.rgb1, 24'hFF0000);

        // Manual writes leave the palette index alone
        do_reset();
        for (int i = 0; i < 4; i++) pulse_next(2'd3);
        check_eq("ch3 to idx0", bus.rgb3, 24'h000000);
        for (int a = 3; a <= 8; a++) do_write(2'd3, 4'(a), 4'h6);
        check_eq("ch3 manual", bus.rgb3, 24'h666666);
        pulse_next(2'd3);
        check_eq("ch3 idx kept", bus.rgb3, 24'hFFFFFF);

        // Same-edge write and step on channel 1 at index 2
        do_reset();
        @(posedge clk);
        #1;
        bus.channel    = 2'd1;
        bus.address    = 4'd3;
        bus.data       = 4'h5;
        bus.valid      = 1'b1;
        bus.color_next = 1'b1;
        @(posedge clk);
        #1;
        check_eq("same edge ack", {23'd0, bus.ack}, 24'd1);
        check_eq("same edge rgb1", bus.rgb1, 24'h50FF00);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("same edge held %0d", i), {23'd0, bus.ack}, 24'd0);
        end
        check_eq("same edge single", bus.rgb1, 24'h50FF00);
        bus.valid      = 1'b0;
        bus.color_next = 1'b0;
        do_write(2'd1, 4'hC, 4'hF);
        check_eq("addr C no change", bus.rgb1, 24'h50FF00);
        do_write(2'd1, 4'd2, 4'hF);
        do_write(2'd1, 4'd9, 4'hF);
        check_eq("addr 2/9 no change", bus.rgb1, 24'h50FF00);
        do_write(2'd1, 4'd8, 4'h3);
        check_eq("addr 8 low nibble", bus.rgb1, 24'h50FF03);
        pulse_next(2'd1);
        check_eq("ch1 step after edits", bus.rgb1, 24'h0000FF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
